apb_boot_sequencer: RTL



---
 rtl/boot_seq_pkg.sv | 38 +++
 rtl/boot_run_timer.sv | 53 +++++
 rtl/apb_boot_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared types and defaults for the APB boot sequencer.
//   boot_state_t      - sequencer FSM states
//   APB_* constants   - {psel, penable} encodings of the APB phases
//   DEF_*             - default parameter values used by the sequencer and its timer
//   apb_phase()       - maps an FSM state to its {psel, penable} pair
package boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SETUP,
        ST_ACCESS,
        ST_CORE_RST,
        ST_RUN,
        ST_FIN
    } boot_state_t;

    // {psel, penable}
    localparam logic [1:0] APB_IDLE   = 2'b00;
    localparam logic [1:0] APB_SETUP  = 2'b10;
    localparam logic [1:0] APB_ACCESS = 2'b11;

    localparam int unsigned DEF_DATA_LENGTH    = 32;
    localparam int unsigned DEF_ADDRESS_LENGTH = 12;
    localparam int unsigned DEF_ADDR_STEP      = 1;
    localparam int unsigned DEF_MAX_WORDS      = 2048;
    localparam int unsigned DEF_RST_CYCLES     = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 40000;

    function automatic logic [1:0] apb_phase(input boot_state_t s);
        logic [1:0] ph;
        ph = APB_IDLE;
        if (s == ST_SETUP)  ph = APB_SETUP;
        if (s == ST_ACCESS) ph = APB_ACCESS;
        return ph;
    endfunction

endpackage

// File: rtl/boot_run_timer.sv
// boot_run_timer: shared cycle counter for the core-reset pulse and the run timeout.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_clear         - restart the count at 0 on the next edge (phase change)
//   i_rst_phase     - count while the core is held in reset
//   i_run_phase     - count while the core is running
//   o_rst_done      - current cycle is the last core-reset cycle
//   o_expire        - current cycle is the last allowed run cycle (never when timeout disabled)
// RST_CYCLES is expected to be at least 1.
module boot_run_timer
    import boot_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_rst_phase,
    input  logic i_run_phase,
    output logic o_rst_done,
    output logic o_expire
);

    localparam int unsigned CNT_MAX  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned RST_LAST = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
    localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] r_cnt;

    // Saturates so a disabled timeout can run forever without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if ((i_rst_phase || i_run_phase) && (r_cnt != CW'(CNT_MAX))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rst_done = (r_cnt == CW'(RST_LAST));

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign o_expire = 1'b0;
        end else begin : g_timeout
            assign o_expire = (r_cnt == CW'(TO_LAST));
        end
    endgenerate

endmodule

// File: rtl/apb_boot_sequencer.sv
// apb_boot_sequencer: loads a program image into core memory over APB, then resets
// and runs the core, reporting completion or timeout.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   start, base_addr                - begin a load/run sequence at base_addr (IDLE/FIN only)
//   s_valid/s_ready/s_data/s_last   - image word stream
//   paddr/pwdata/psel/penable/pwrite/pready - APB master write port
//   core_select, core_rst_n         - memory port hand-over and core reset
//   run_complete                    - core finished
//   busy, done, timeout, overflow   - status (done/timeout/overflow sticky until start)
//   word_count                      - words written in the current sequence
//   load_checksum                   - only with BOOT_CHECKSUM_EN: sum of written words
module apb_boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned DATA_LENGTH    = DEF_DATA_LENGTH,
    parameter int unsigned ADDRESS_LENGTH = DEF_ADDRESS_LENGTH,
    parameter int unsigned ADDR_STEP      = DEF_ADDR_STEP,
    parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDRESS_LENGTH-1:0]         base_addr,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_LENGTH-1:0]            s_data,
    input  logic                              s_last,
    output logic [ADDRESS_LENGTH-1:0]         paddr,
    output logic [DATA_LENGTH-1:0]            pwdata,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    input  logic                              pready,
    output logic                              core_select,
    output logic                              core_rst_n,
    input  logic                              run_complete,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout,
    output logic                              overflow,
    output logic [$clog2(MAX_WORDS+1)-1:0]    word_count
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [DATA_LENGTH-1:0]            load_checksum
`endif
);

    localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);

    boot_state_t               r_state;
    boot_state_t               w_next;

    logic [ADDRESS_LENGTH-1:0] r_addr;
    logic [ADDRESS_LENGTH-1:0] r_paddr;
    logic [DATA_LENGTH-1:0]    r_pwdata;
    logic                      r_last;
    logic [WC_W-1:0]           r_wc;
    logic                      r_done;
    logic                      r_timeout;
    logic                      r_overflow;
    logic                      r_core_sel;

    logic                      w_s_ready;
    logic                      w_pwrite;
    logic                      w_busy;
    logic                      w_core_rst_n;
    logic [1:0]                w_phase;
    logic                      w_start_ok;
    logic                      w_take;
    logic                      w_xfer;
    logic [WC_W-1:0]           w_wc_inc;
    logic                      w_wc_full;
    logic                      w_ovf;
    logic                      w_rst_phase;
    logic                      w_run_phase;
    logic                      w_tmr_clear;
    logic                      w_rst_done;
    logic                      w_expire;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_take      = (r_state == ST_ACCEPT) && s_valid;
    assign w_xfer      = (r_state == ST_ACCESS) && pready;
    assign w_wc_inc    = r_wc + WC_W'(1);
    assign w_wc_full   = (w_wc_inc == WC_W'(MAX_WORDS));
    assign w_ovf       = w_xfer && !r_last && w_wc_full;
    assign w_rst_phase = (r_state == ST_CORE_RST);
    assign w_run_phase = (r_state == ST_RUN);
    // Any state change restarts the timer, so each phase counts from 0.
    assign w_tmr_clear = (w_next != r_state);

    boot_run_timer #(
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_tmr_clear),
        .i_rst_phase (w_rst_phase),
        .i_run_phase (w_run_phase),
        .o_rst_done  (w_rst_done),
        .o_expire    (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_s_ready    = 1'b0;
        w_pwrite     = 1'b0;
        w_busy       = 1'b1;
        w_core_rst_n = 1'b1;
        w_phase      = apb_phase(r_state);
        case (r_state)
            ST_IDLE, ST_FIN: begin
                w_busy = 1'b0;
                if (start) w_next = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                w_s_ready = 1'b1;
                if (s_valid) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_pwrite = 1'b1;
                w_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_pwrite = 1'b1;
                if (pready) begin
                    if (r_last)         w_next = ST_CORE_RST;
                    else if (w_wc_full) w_next = ST_FIN;
                    else                w_next = ST_ACCEPT;
                end
            end
            ST_CORE_RST: begin
                w_core_rst_n = 1'b0;
                if (w_rst_done) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (run_complete || w_expire) w_next = ST_FIN;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_last     <= 1'b0;
            r_wc       <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
            r_core_sel <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_addr     <= base_addr;
                r_wc       <= '0;
                r_done     <= 1'b0;
                r_timeout  <= 1'b0;
                r_overflow <= 1'b0;
                r_core_sel <= 1'b0;
            end
            if (w_take) begin
                r_paddr  <= r_addr;
                r_pwdata <= s_data;
                r_last   <= s_last;
            end
            if (w_xfer) begin
                r_wc   <= w_wc_inc;
                r_addr <= r_addr + ADDRESS_LENGTH'(ADDR_STEP);
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            // Core keeps the memory port from its reset pulse until the next start.
            if ((r_state == ST_ACCESS) && (w_next == ST_CORE_RST)) begin
                r_core_sel <= 1'b1;
            end
            // Completion takes priority over a simultaneous expiry.
            if (r_state == ST_RUN) begin
                if (run_complete)  r_done    <= 1'b1;
                else if (w_expire) r_timeout <= 1'b1;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_LENGTH-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_xfer) begin
            r_csum <= r_csum + r_pwdata;
        end
    end

    assign load_checksum = r_csum;
`endif

    assign s_ready     = w_s_ready;
    assign psel        = w_phase[1];
    assign penable     = w_phase[0];
    assign pwrite      = w_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign core_select = r_core_sel;
    assign core_rst_n  = w_core_rst_n;
    assign busy        = w_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign word_count  = r_wc;

endmodule
